// File: rtl/exec_pkg.sv
// Shared types and default widths for the execute/writeback stage.
// Optional operand forwarding is enabled with the EXEC_FWD_EN macro.
package exec_pkg;

  localparam int unsigned EXEC_DW = 8;
  localparam int unsigned EXEC_AW = 3;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SHL  = 4'd5,
    OP_SHR  = 4'd6,
    OP_PASS = 4'd7,
    OP_MUL  = 4'd8,
    OP_NOP  = 4'd15
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/exec_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, LSB first.
// The low product byte builds up in the multiplier register as it shifts out.
module exec_mul #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          run,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          done_c,
  output logic [DW-1:0] prod_c,
  output logic          hi_nz_c
);

  localparam int unsigned CW = $clog2(DW);

  logic [DW-1:0] mcand_q, mcand_d;
  logic [DW-1:0] mplier_q, mplier_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW:0]   sum;
  logic [DW-1:0] step_acc;
  logic [DW-1:0] step_mplier;

  // One shift-add step; the sum's LSB drops into the vacated multiplier MSB.
  always_comb begin
    sum         = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    step_acc    = sum[DW:1];
    step_mplier = {sum[0], mplier_q[DW-1:1]};

    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (start) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (run) begin
      mplier_d = step_mplier;
      acc_d    = step_acc;
      cnt_d    = cnt_q + CW'(1);
    end

    done_c  = run && (cnt_q == CW'(DW - 1));
    prod_c  = step_mplier;
    hi_nz_c = (step_acc != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/exec_stage.sv
// Execute/writeback stage: single-cycle ALU plus 8-cycle multiply feeding the regfile write port.
// Define EXEC_FWD_EN to forward the previous writeback onto matching source operands.
module exec_stage
  import exec_pkg::*;
#(
  parameter int unsigned DW = EXEC_DW,
  parameter int unsigned AW = EXEC_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    op,
  input  logic [AW-1:0] ra,
  input  logic [AW-1:0] rb,
  input  logic [AW-1:0] rd,
  input  logic [DW-1:0] opa,
  input  logic [DW-1:0] opb,
  output logic          wb_en,
  output logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wb_data,
  output logic          flag_c,
  output logic          flag_z,
  output logic          busy
);

  state_t        state_q, state_d;
  logic          wb_en_q, wb_en_d;
  logic [AW-1:0] wb_addr_q, wb_addr_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic          flag_c_q, flag_c_d;
  logic          flag_z_q, flag_z_d;
  logic          busy_q, busy_d;
  logic [AW-1:0] mul_rd_q, mul_rd_d;

  logic [DW-1:0] opa_eff, opb_eff;
  logic [DW-1:0] alu_res;
  logic          alu_c;
  logic          alu_wr;
  logic [DW:0]   alu_sum;
  logic          mul_start;
  logic          mul_done;
  logic [DW-1:0] mul_prod;
  logic          mul_hi_nz;

`ifdef EXEC_FWD_EN
  assign opa_eff = (wb_en_q && (wb_addr_q == ra)) ? wb_data_q : opa;
  assign opb_eff = (wb_en_q && (wb_addr_q == rb)) ? wb_data_q : opb;
`else
  logic unused_src_addr;
  assign unused_src_addr = ^{ra, rb};
  assign opa_eff = opa;
  assign opb_eff = opb;
`endif

  // Single-cycle ALU; reserved encodings fall through as no-writeback.
  always_comb begin
    alu_sum = '0;
    alu_res = '0;
    alu_c   = flag_c_q;
    alu_wr  = 1'b1;
    case (op_t'(op))
      OP_ADD: begin
        alu_sum = {1'b0, opa_eff} + {1'b0, opb_eff};
        alu_res = alu_sum[DW-1:0];
        alu_c   = alu_sum[DW];
      end
      OP_SUB: begin
        alu_sum = {1'b0, opa_eff} - {1'b0, opb_eff};
        alu_res = alu_sum[DW-1:0];
        alu_c   = alu_sum[DW];
      end
      OP_AND:  alu_res = opa_eff & opb_eff;
      OP_OR:   alu_res = opa_eff | opb_eff;
      OP_XOR:  alu_res = opa_eff ^ opb_eff;
      OP_SHL: begin
        alu_res = {opa_eff[DW-2:0], 1'b0};
        alu_c   = opa_eff[DW-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, opa_eff[DW-1:1]};
        alu_c   = opa_eff[0];
      end
      OP_PASS: alu_res = opb_eff;
      default: alu_wr = 1'b0;
    endcase
  end

  exec_mul #(.DW(DW)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .run     (state_q == ST_MUL),
    .a       (opa_eff),
    .b       (opb_eff),
    .done_c  (mul_done),
    .prod_c  (mul_prod),
    .hi_nz_c (mul_hi_nz)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    wb_en_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    flag_c_d  = flag_c_q;
    flag_z_d  = flag_z_q;
    mul_rd_d  = mul_rd_q;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (op_t'(op) == OP_MUL) begin
            mul_start = 1'b1;
            mul_rd_d  = rd;
            state_d   = ST_MUL;
          end else if (alu_wr) begin
            wb_en_d   = 1'b1;
            wb_addr_d = rd;
            wb_data_d = alu_res;
            flag_c_d  = alu_c;
            flag_z_d  = (alu_res == '0);
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          state_d   = ST_DONE;
          wb_en_d   = 1'b1;
          wb_addr_d = mul_rd_q;
          wb_data_d = mul_prod;
          flag_c_d  = mul_hi_nz;
          flag_z_d  = (mul_prod == '0);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      flag_c_q  <= 1'b0;
      flag_z_q  <= 1'b0;
      busy_q    <= 1'b0;
      mul_rd_q  <= '0;
    end else begin
      state_q   <= state_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      flag_c_q  <= flag_c_d;
      flag_z_q  <= flag_z_d;
      busy_q    <= busy_d;
      mul_rd_q  <= mul_rd_d;
    end
  end

  assign in_ready = (state_q == ST_IDLE);
  assign wb_en    = wb_en_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;
  assign flag_c   = flag_c_q;
  assign flag_z   = flag_z_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage with hand-computed expected writebacks and flags.
module tb_exec_stage;
  import exec_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op;
  logic [2:0] ra, rb, rd;
  logic [7:0] opa, opb;
  logic       wb_en;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;
  logic       flag_c, flag_z, busy;

  int n_vec = 0;
  int n_err = 0;

  exec_stage dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .ra       (ra),
    .rb       (rb),
    .rd       (rd),
    .opa      (opa),
    .opb      (opb),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .flag_c   (flag_c),
    .flag_z   (flag_z),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] o, input logic [2:0] a_addr, input logic [2:0] b_addr,
                       input logic [2:0] d_addr, input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    op       = o;
    ra       = a_addr;
    rb       = b_addr;
    rd       = d_addr;
    opa      = a;
    opb      = b;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    op       = OP_NOP;
  endtask

  // Issue one single-cycle op and check the writeback that follows.
  task automatic alu_vec(input string tag, input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_d, input logic exp_c, input logic exp_z);
    drive(o, 3'd6, 3'd7, 3'd1, a, b);
    tick();
    idle();
    check({tag, "_en"}, wb_en, 1'b1);
    check({tag, "_data"}, wb_data, exp_d);
    check({tag, "_c"}, flag_c, exp_c);
    check({tag, "_z"}, flag_z, exp_z);
  endtask

  // Issue a multiply and check the 9-cycle busy window and single writeback.
  task automatic mul_vec(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [2:0] d,
                         input logic [7:0] exp_d, input logic exp_c);
    int pulses;
    pulses = 0;
    drive(OP_MUL, 3'd6, 3'd7, d, a, b);
    check({tag, "_rdy_pre"}, in_ready, 1'b1);
    tick();
    idle();
    for (int i = 0; i < 9; i++) begin
      check({tag, "_rdy"}, in_ready, 1'b0);
      check({tag, "_busy"}, busy, 1'b1);
      if (wb_en) pulses++;
      if (i < 8) tick();
    end
    check({tag, "_en"}, wb_en, 1'b1);
    check({tag, "_addr"}, wb_addr, d);
    check({tag, "_data"}, wb_data, exp_d);
    check({tag, "_c"}, flag_c, exp_c);
    check({tag, "_pulses"}, pulses, 1);
    tick();
    check({tag, "_en_after"}, wb_en, 1'b0);
    check({tag, "_busy_after"}, busy, 1'b0);
    check({tag, "_rdy_after"}, in_ready, 1'b1);
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0;
    idle();
    ra = '0; rb = '0; rd = '0; opa = '0; opb = '0;
    tick();
    tick();
    check("rst_wb_en", wb_en, 1'b0);
    check("rst_wb_addr", wb_addr, 3'd0);
    check("rst_wb_data", wb_data, 8'h00);
    check("rst_flag_c", flag_c, 1'b0);
    check("rst_flag_z", flag_z, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    tick();

    // ADD with carry out
    drive(OP_ADD, 3'd1, 3'd2, 3'd3, 8'hF0, 8'h20);
    tick();
    idle();
    check("add_en", wb_en, 1'b1);
    check("add_addr", wb_addr, 3'd3);
    check("add_data", wb_data, 8'h10);
    check("add_c", flag_c, 1'b1);
    check("add_z", flag_z, 1'b0);

    // SUB then XOR back-to-back
    drive(OP_SUB, 3'd6, 3'd7, 3'd4, 8'h05, 8'h05);
    tick();
    check("sub_en", wb_en, 1'b1);
    check("sub_data", wb_data, 8'h00);
    check("sub_z", flag_z, 1'b1);
    check("sub_c", flag_c, 1'b0);
    drive(OP_XOR, 3'd6, 3'd7, 3'd5, 8'hAA, 8'hFF);
    tick();
    idle();
    check("xor_en", wb_en, 1'b1);
    check("xor_addr", wb_addr, 3'd5);
    check("xor_data", wb_data, 8'h55);
    check("xor_z", flag_z, 1'b0);
    check("xor_c", flag_c, 1'b0);
    tick();
    check("idle_en", wb_en, 1'b0);
    check("idle_hold_data", wb_data, 8'h55);
    check("idle_hold_addr", wb_addr, 3'd5);

    // Remaining ALU ops; carry is unchanged by AND/OR/PASS
    alu_vec("shl1", OP_SHL, 8'h81, 8'h00, 8'h02, 1'b1, 1'b0);
    alu_vec("and", OP_AND, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b1);
    alu_vec("shr", OP_SHR, 8'h02, 8'h00, 8'h01, 1'b0, 1'b0);
    alu_vec("or", OP_OR, 8'h80, 8'h01, 8'h81, 1'b0, 1'b0);
    alu_vec("pass", OP_PASS, 8'h33, 8'h5A, 8'h5A, 1'b0, 1'b0);
    alu_vec("shl2", OP_SHL, 8'h40, 8'h00, 8'h80, 1'b0, 1'b0);
    alu_vec("sub_brw", OP_SUB, 8'h01, 8'h02, 8'hFF, 1'b1, 1'b0);
    alu_vec("add_wrap", OP_ADD, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1);

    // Reserved and NOP encodings: no writeback, flags held
    drive(4'd9, 3'd6, 3'd7, 3'd2, 8'h01, 8'h01);
    tick();
    check("rsv_en", wb_en, 1'b0);
    drive(OP_NOP, 3'd6, 3'd7, 3'd2, 8'h01, 8'h01);
    tick();
    idle();
    check("nop_en", wb_en, 1'b0);
    check("nop_c", flag_c, 1'b1);
    check("nop_z", flag_z, 1'b1);
    check("nop_data", wb_data, 8'h00);

    // Multiplies
    mul_vec("mul_ff2", 8'hFF, 8'h02, 3'd4, 8'hFE, 1'b1);
    mul_vec("mul_13x11", 8'd13, 8'd11, 3'd5, 8'h8F, 1'b0);

    // ADD held valid across a MUL waits for in_ready
    drive(OP_MUL, 3'd6, 3'd7, 3'd1, 8'd3, 8'd4);
    tick();
    drive(OP_ADD, 3'd6, 3'd7, 3'd3, 8'h01, 8'h02);
    for (int i = 0; i < 8; i++) begin
      check("hold_rdy", in_ready, 1'b0);
      check("hold_no_wb", wb_en, 1'b0);
      tick();
    end
    check("hold_mul_en", wb_en, 1'b1);
    check("hold_mul_addr", wb_addr, 3'd1);
    check("hold_mul_data", wb_data, 8'h0C);
    check("hold_mul_rdy", in_ready, 1'b0);
    tick();
    check("hold_gap_en", wb_en, 1'b0);
    check("hold_gap_rdy", in_ready, 1'b1);
    tick();
    idle();
    check("hold_add_en", wb_en, 1'b1);
    check("hold_add_addr", wb_addr, 3'd3);
    check("hold_add_data", wb_data, 8'h03);
    tick();

    // Dependent ADD immediately after producer
    drive(OP_ADD, 3'd0, 3'd1, 3'd2, 8'h03, 8'h04);
    tick();
    check("fwd_prod", wb_data, 8'h07);
    drive(OP_ADD, 3'd2, 3'd7, 3'd5, 8'h00, 8'h01);
    tick();
    idle();
`ifdef EXEC_FWD_EN
    check("fwd_cons", wb_data, 8'h08);
`else
    check("fwd_cons", wb_data, 8'h01);
`endif
    tick();

    // Reset during a multiply discards the result
    drive(OP_MUL, 3'd6, 3'd7, 3'd4, 8'd5, 8'd5);
    tick();
    idle();
    tick();
    tick();
    tick();
    check("mrst_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mrst_busy", busy, 1'b0);
    check("mrst_rdy", in_ready, 1'b1);
    check("mrst_en", wb_en, 1'b0);
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (wb_en) pulses++;
    end
    check("mrst_no_wb", pulses, 0);
    check("mrst_busy_post", busy, 1'b0);
    drive(OP_ADD, 3'd6, 3'd7, 3'd3, 8'h10, 8'h20);
    tick();
    idle();
    check("mrst_add_en", wb_en, 1'b1);
    check("mrst_add_data", wb_data, 8'h30);
    check("mrst_add_addr", wb_addr, 3'd3);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/exec_stage.md
Name: exec_stage

Overview:
- Execute/writeback stage directly downstream of the 8-entry, 8-bit register file.
- Consumes the two read operands plus decoded op, dest and source addresses.
- Single-cycle ALU ops; iterative 8-cycle multiply.
- Drives the register file's write port (enable, address, data) from registered outputs.
- Carries a valid/ready handshake to the decode stage and a carry/zero flag register.

Parameters:
DW, 8, operand/result width
AW, 3, register address width (8 registers)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  decode presents an instruction
in_ready  out  1  stage can accept this cycle
op  in  4  opcode, encodings in package
ra  in  AW  source A address (for forwarding compare)
rb  in  AW  source B address
rd  in  AW  destination address
opa  in  DW  register-file read data A
opb  in  DW  register-file read data B
wb_en  out  1  register-file write enable, one-cycle pulse per result
wb_addr  out  AW  register-file write address
wb_data  out  DW  register-file write data
flag_c  out  1  carry/borrow flag
flag_z  out  1  zero flag
busy  out  1  multiply in progress

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values: wb_en=0, wb_addr=0, wb_data=0, flag_c=0, flag_z=0, busy=0, state=IDLE, in_ready=1 after reset release.
- Accept: an instruction is accepted when in_valid && in_ready at a rising edge.
- in_ready: in_ready = (state==IDLE), combinational from state.
- Ops:
  - ADD: 9-bit sum; flag_c=bit8.
  - SUB: opa-opb; flag_c=borrow.
  - AND, OR, XOR: flag_c unchanged.
  - SHL: opa<<1; flag_c=opa[7].
  - SHR: logical opa>>1; flag_c=opa[0].
  - PASS: result=opb; flag_c unchanged.
  - NOP: no writeback, flags unchanged.
  - MUL: low DW bits of opa*opb; flag_c=1 if the high byte is nonzero.
- flag_z: updates with every writeback, 1 iff the result == 0.
- Single-cycle ops: result registered at the accept edge.
  - wb_en=1 for exactly the following cycle, with wb_addr=rd and wb_data=result.
  - Latency 1. Back-to-back issue every cycle is allowed.
- FSM states: IDLE, MUL, DONE.
  - IDLE --accept MUL--> MUL: latch multiplicand, multiplier and rd; clear the 8-bit accumulator and the 3-bit counter.
  - MUL: shift-add, one multiplier bit per cycle (LSB first); counter increments.
  - MUL --counter==7--> DONE. Eight cycles in MUL. Track the high byte for the carry flag.
  - DONE: wb_en=1 with the product, busy still 1, in_ready=0. Next state IDLE.
- MUL latency: 9 cycles from the accept edge to the wb_en pulse; next accept no earlier than the cycle after DONE.
- busy=1 in MUL and DONE.
- wb_en when not producing a result: 0, wb_addr/wb_data hold their last values.
- Invalid or reserved op encodings behave as NOP.
- Reset mid-multiply: returns to IDLE immediately and the result is discarded; no wb_en pulse.
- Arithmetic: all wrap modulo 2^DW; no saturation.

Optional Feature:
- Macro: EXEC_FWD_EN.
- Defined: forwarding hazard fix.
  - If wb_en && wb_addr==ra at the accept edge, the effective opa is wb_data, not the register-file value. Same for rb/opb.
  - Both may forward at once.
  - Forwarding also applies to the MUL operand latch.
- Not defined: no forwarding logic. Decode must insert one NOP between dependent instructions; operands are used as presented.

Decomposition:
- Package exec_pkg holds:
  - the op_t enum: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SHL=5, SHR=6, PASS=7, MUL=8, NOP=15;
  - the state_t enum: IDLE, MUL, DONE;
  - the DW/AW defaults.
- One sub-module is natural: exec_mul, the iterative shift-add multiplier with its counter and start/done pulses. The ALU remains inline combinational logic.

Test Plan:
- Reset release, then ADD ra=1 (opa=8'hF0), rb=2 (opb=8'h20), rd=3 -> next cycle wb_en=1, wb_addr=3, wb_data=8'h10, flag_c=1, flag_z=0.
- SUB 8'h05-8'h05 then XOR 8'hAA^8'hFF back-to-back -> wb_data 8'h00 with flag_z=1, flag_c=0, then 8'h55 with flag_z=0; wb_en high two consecutive cycles.
- MUL 8'd13*8'd11, rd=5 -> in_ready=0 and busy=1 for 9 cycles; single wb_en with wb_data=8'h8F, wb_addr=5, flag_c=0.
  - 8'hFF*8'h02 -> wb_data=8'hFE, flag_c=1.
- in_valid held with ADD during a MUL -> not accepted until in_ready=1; its wb_en comes 1 cycle after acceptance, after the MUL writeback.
- EXEC_FWD_EN: ADD rd=2 result 8'h07, then in the next cycle ADD ra=2 (stale opa=8'h00), opb=8'h01 -> wb_data=8'h08.
  - Without the macro: wb_data=8'h01.
- rst_n low at cycle 4 of a MUL -> busy=0, in_ready=1, wb_en never asserted; a new ADD after release completes normally.
